// File: rtl/peribus_timer.sv
// Prescaled 16-bit timer/counter responding on the peripheral bus, with level irq.
// Optional input capture unit enabled by defining PERIBUS_TIMER_CAPTURE_EN.
module peribus_timer #(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  addr,
    input  logic [15:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [15:0] read_data,
    output logic        irq
`ifdef PERIBUS_TIMER_CAPTURE_EN
    ,
    input  logic        capture_in
`endif
);

    localparam int unsigned DATA_W = 16;
`ifdef PERIBUS_TIMER_CAPTURE_EN
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned STAT_W = 3;
`else
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned STAT_W = 2;
`endif

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_RELOAD   = 3'd3;
    localparam logic [2:0] OFF_COMPARE  = 3'd4;
    localparam logic [2:0] OFF_PRESCALE = 3'd5;
`ifdef PERIBUS_TIMER_CAPTURE_EN
    localparam logic [2:0] OFF_CAPTURE  = 3'd6;
`endif

    logic                we_q;
    logic [CTRL_W-1:0]   ctrl,      ctrl_nxt;
    logic [STAT_W-1:0]   status,    status_nxt;
    logic [DATA_W-1:0]   count,     count_nxt;
    logic [DATA_W-1:0]   reload;
    logic [DATA_W-1:0]   compare;
    logic [DATA_W-1:0]   prescale;
    logic [DATA_W-1:0]   presc_cnt, presc_nxt;
`ifdef PERIBUS_TIMER_CAPTURE_EN
    logic                cap_meta, cap_sync, cap_sync_q;
    logic [DATA_W-1:0]   capture,   capture_nxt;
    logic                cap_edge_c;
`endif

    logic                in_win_c;
    logic [2:0]          off_c;
    logic                commit_c;
    logic                wr_ctrl_c, wr_status_c, wr_count_c;
    logic                wr_reload_c, wr_compare_c, wr_prescale_c;
    logic                tick_raw_c, tick_c, wrap_c;
    logic                ovf_set_c, cmp_set_c;
    logic [DATA_W-1:0]   count_tick_c;
    logic [STAT_W-1:0]   set_c, w1c_c;
    logic [DATA_W-1:0]   rd_val_c;
    logic                irq_nxt_c;

    // Window decode in 9 bits so a base near the top of the space cannot wrap.
    assign in_win_c = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 9'd7));
    assign off_c    = 3'(addr - BASE_ADDR);
    assign commit_c = write_enable && !we_q && in_win_c;

    assign wr_ctrl_c     = commit_c && (off_c == OFF_CTRL);
    assign wr_status_c   = commit_c && (off_c == OFF_STATUS);
    assign wr_count_c    = commit_c && (off_c == OFF_COUNT);
    assign wr_reload_c   = commit_c && (off_c == OFF_RELOAD);
    assign wr_compare_c  = commit_c && (off_c == OFF_COMPARE);
    assign wr_prescale_c = commit_c && (off_c == OFF_PRESCALE);

`ifdef PERIBUS_TIMER_CAPTURE_EN
    assign cap_edge_c = cap_sync && !cap_sync_q;
`endif

    // Timer datapath, status flags and read mux.
    always_comb begin
        tick_raw_c   = ctrl[0] && (presc_cnt == prescale);
        // A COUNT write or an EN-clearing CTRL write swallows a coincident tick.
        tick_c       = tick_raw_c && !wr_count_c && !(wr_ctrl_c && !write_data[0]);
        wrap_c       = (count == 16'hFFFF);
        count_tick_c = wrap_c ? (ctrl[1] ? reload : '0) : count + 16'd1;
        ovf_set_c    = tick_c && wrap_c;
        cmp_set_c    = tick_c && (count_tick_c == compare);

        ctrl_nxt = ctrl;
        if (ovf_set_c && !ctrl[1]) begin
            ctrl_nxt[0] = 1'b0;
        end
        if (wr_ctrl_c) begin
            ctrl_nxt = write_data[CTRL_W-1:0];
        end

        count_nxt = count;
        if (tick_c) begin
            count_nxt = count_tick_c;
        end
        if (wr_count_c) begin
            count_nxt = write_data;
        end

        // Covers EN low, the EN rising commit (pre-edge EN is 0) and EN falling.
        presc_nxt = presc_cnt + 16'd1;
        if (!ctrl[0] || !ctrl_nxt[0] || tick_raw_c || wr_prescale_c) begin
            presc_nxt = '0;
        end

        set_c    = '0;
        set_c[0] = ovf_set_c;
        set_c[1] = cmp_set_c;
`ifdef PERIBUS_TIMER_CAPTURE_EN
        set_c[2]    = cap_edge_c;
        capture_nxt = cap_edge_c ? count : capture;
`endif
        w1c_c      = wr_status_c ? write_data[STAT_W-1:0] : '0;
        status_nxt = (status & ~w1c_c) | set_c;

        rd_val_c = '0;
        case (off_c)
            OFF_CTRL:     rd_val_c = DATA_W'(ctrl);
            OFF_STATUS:   rd_val_c = DATA_W'(status);
            OFF_COUNT:    rd_val_c = count;
            OFF_RELOAD:   rd_val_c = reload;
            OFF_COMPARE:  rd_val_c = compare;
            OFF_PRESCALE: rd_val_c = prescale;
`ifdef PERIBUS_TIMER_CAPTURE_EN
            OFF_CAPTURE:  rd_val_c = capture;
`endif
            default:      rd_val_c = '0;
        endcase

        irq_nxt_c = |(status & ctrl[CTRL_W-1:2]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q      <= 1'b0;
            ctrl      <= '0;
            status    <= '0;
            count     <= '0;
            reload    <= '0;
            compare   <= '0;
            prescale  <= '0;
            presc_cnt <= '0;
            read_data <= '0;
            irq       <= 1'b0;
`ifdef PERIBUS_TIMER_CAPTURE_EN
            cap_meta   <= 1'b0;
            cap_sync   <= 1'b0;
            cap_sync_q <= 1'b0;
            capture    <= '0;
`endif
        end else begin
            we_q      <= write_enable;
            ctrl      <= ctrl_nxt;
            status    <= status_nxt;
            count     <= count_nxt;
            presc_cnt <= presc_nxt;
            if (wr_reload_c) begin
                reload <= write_data;
            end
            if (wr_compare_c) begin
                compare <= write_data;
            end
            if (wr_prescale_c) begin
                prescale <= write_data;
            end
            read_data <= (read_enable && in_win_c) ? rd_val_c : '0;
            irq       <= irq_nxt_c;
`ifdef PERIBUS_TIMER_CAPTURE_EN
            cap_meta   <= capture_in;
            cap_sync   <= cap_meta;
            cap_sync_q <= cap_sync;
            capture    <= capture_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_peribus_timer.sv
// Directed self-checking bench for peribus_timer; bus driven and sampled on negedge.
module tb_peribus_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic        clock;
    logic        reset_n;
    logic [7:0]  addr;
    logic [15:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] read_data;
    logic        irq;
`ifdef PERIBUS_TIMER_CAPTURE_EN
    logic        capture_in;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] d;

    peribus_timer #(.BASE_ADDR(BASE)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .addr         (addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .irq          (irq)
`ifdef PERIBUS_TIMER_CAPTURE_EN
        ,
        .capture_in   (capture_in)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ra(input int unsigned off);
        return BASE + 8'(off);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [15:0] wd);
        @(negedge clock);
        addr         = a;
        write_data   = wd;
        write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [15:0] rd);
        @(negedge clock);
        addr        = a;
        read_enable = 1'b1;
        @(negedge clock);
        rd          = read_data;
        read_enable = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        addr         = '0;
        write_data   = '0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
`ifdef PERIBUS_TIMER_CAPTURE_EN
        capture_in   = 1'b0;
`endif
        cycles(3);
        reset_n = 1'b1;

        // Reset state: every offset reads zero, irq low.
        check_eq("rst_irq", 16'(irq), 16'h0000);
        check_eq("rst_rdata", read_data, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            bus_read(ra(i), d);
            check_eq($sformatf("rst_off%0d", i), d, 16'h0000);
        end

        // Held write_enable commits once, with data sampled on the first clock.
        @(negedge clock);
        addr         = ra(2);
        write_data   = 16'h1234;
        write_enable = 1'b1;
        @(negedge clock);
        write_data   = 16'hBEEF;
        cycles(3);
        write_enable = 1'b0;
        bus_read(ra(2), d);
        check_eq("hold_commit", d, 16'h1234);
        bus_write(BASE + 8'd8, 16'hFFFF);
        bus_read(ra(2), d);
        check_eq("oow_count", d, 16'h1234);
        bus_read(ra(0), d);
        check_eq("oow_ctrl", d, 16'h0000);
        bus_read(BASE + 8'd8, d);
        check_eq("oow_read", d, 16'h0000);
        @(negedge clock);
        addr        = ra(2);
        read_enable = 1'b0;
        @(negedge clock);
        check_eq("no_re_read", read_data, 16'h0000);
        bus_write(ra(7), 16'hFFFF);
        bus_read(ra(7), d);
        check_eq("off7_read", d, 16'h0000);

        // Auto-reload overflow with prescale 3.
        bus_write(ra(5), 16'd3);
        bus_write(ra(2), 16'hFFFE);
        bus_write(ra(3), 16'h8000);
        bus_write(ra(0), 16'h0007);
        cycles(3);
        bus_read(ra(2), d);
        check_eq("cnt_ffff", d, 16'hFFFF);
        cycles(2);
        bus_read(ra(2), d);
        check_eq("cnt_reload", d, 16'h8000);
        check_eq("ovf_irq", 16'(irq), 16'h0001);
        bus_read(ra(1), d);
        check_eq("ovf_status", d, 16'h0001);
        bus_write(ra(1), 16'h0001);
        cycles(1);
        check_eq("ovf_irq_clr", 16'(irq), 16'h0000);
        bus_read(ra(1), d);
        check_eq("ovf_w1c", d, 16'h0000);
        bus_write(ra(0), 16'h0000);

        // One-shot: overflow clears EN and COUNT; next value 0 matches COMPARE=0.
        bus_write(ra(5), 16'd0);
        bus_write(ra(2), 16'hFFFF);
        bus_write(ra(0), 16'h0001);
        cycles(2);
        bus_read(ra(2), d);
        check_eq("os_count", d, 16'h0000);
        bus_read(ra(0), d);
        check_eq("os_ctrl", d, 16'h0000);
        bus_read(ra(1), d);
        check_eq("os_status", d, 16'h0003);
        check_eq("os_irq", 16'(irq), 16'h0000);
        cycles(5);
        bus_read(ra(2), d);
        check_eq("os_hold", d, 16'h0000);
        bus_write(ra(1), 16'h0003);

        // Compare match with CMP_IE.
        bus_write(ra(4), 16'h0005);
        bus_write(ra(2), 16'h0003);
        bus_write(ra(0), 16'h0009);
        bus_read(ra(1), d);
        check_eq("cmp_pre", d, 16'h0000);
        check_eq("cmp_irq_pre", 16'(irq), 16'h0000);
        cycles(1);
        check_eq("cmp_irq", 16'(irq), 16'h0001);
        bus_read(ra(1), d);
        check_eq("cmp_status", d, 16'h0002);

        // COUNT write on a tick that would have produced 5: write wins, no CMP.
        bus_write(ra(0), 16'h0000);
        bus_write(ra(1), 16'h0002);
        bus_write(ra(5), 16'd1);
        bus_write(ra(2), 16'h0004);
        bus_write(ra(0), 16'h0009);
        bus_write(ra(2), 16'h0005);
        bus_read(ra(2), d);
        check_eq("wr_tick_count", d, 16'h0005);
        bus_read(ra(1), d);
        check_eq("wr_tick_nocmp", d, 16'h0000);
        check_eq("wr_tick_irq", 16'(irq), 16'h0000);

        // CTRL unused bits read zero.
        bus_write(ra(0), 16'h0000);
        bus_write(ra(0), 16'hFFFF);
        bus_read(ra(0), d);
`ifdef PERIBUS_TIMER_CAPTURE_EN
        check_eq("ctrl_mask", d, 16'h001F);
`else
        check_eq("ctrl_mask", d, 16'h000F);
`endif
        bus_write(ra(0), 16'h0000);
        bus_write(ra(1), 16'h0007);

`ifdef PERIBUS_TIMER_CAPTURE_EN
        // Capture latches COUNT seen 3 clocks after the edge.
        bus_write(ra(5), 16'd0);
        bus_write(ra(2), 16'h0100);
        bus_write(ra(0), 16'h0011);
        capture_in = 1'b1;
        cycles(5);
        capture_in = 1'b0;
        bus_read(ra(6), d);
        check_eq("cap_value", d, 16'h0102);
        bus_read(ra(1), d);
        check_eq("cap_status", d, 16'h0004);
        check_eq("cap_irq", 16'(irq), 16'h0001);
        bus_write(ra(1), 16'h0004);
        bus_write(ra(0), 16'h0000);
`endif

        // Reset while running clears everything.
        bus_write(ra(0), 16'h0007);
        cycles(3);
        #2 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_eq("mrst_irq", 16'(irq), 16'h0000);
        bus_read(ra(2), d);
        check_eq("mrst_count", d, 16'h0000);
        bus_read(ra(0), d);
        check_eq("mrst_ctrl", d, 16'h0000);
        bus_read(ra(4), d);
        check_eq("mrst_compare", d, 16'h0000);
        bus_read(ra(5), d);
        check_eq("mrst_prescale", d, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
